// File: rtl/snitch_fpu_share_arbiter.sv
// Shares one FPU between NumPorts cores: round-robin request arbitration with grant lock,
// index-tagged response routing and per-port outstanding-credit counters.
module snitch_fpu_share_arbiter #(
   parameter int unsigned NumPorts       = 2,
   parameter int unsigned ReqWidth       = 128,
   parameter int unsigned RspWidth       = 69,
   parameter int unsigned TagWidth       = 7,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned IdxWidth       = $clog2(NumPorts)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumPorts-1:0]          req_valid_i,
   output logic [NumPorts-1:0]          req_ready_o,
   input  logic [NumPorts*ReqWidth-1:0] req_data_i,
   input  logic [NumPorts*TagWidth-1:0] req_tag_i,
   output logic                         fpu_valid_o,
   input  logic                         fpu_ready_i,
   output logic [ReqWidth-1:0]          fpu_data_o,
   output logic [TagWidth+IdxWidth-1:0] fpu_tag_o,
   input  logic                         fpu_rsp_valid_i,
   output logic                         fpu_rsp_ready_o,
   input  logic [RspWidth-1:0]          fpu_rsp_data_i,
   input  logic [TagWidth+IdxWidth-1:0] fpu_rsp_tag_i,
   output logic [NumPorts-1:0]          rsp_valid_o,
   input  logic [NumPorts-1:0]          rsp_ready_i,
   output logic [RspWidth-1:0]          rsp_data_o,
   output logic [TagWidth-1:0]          rsp_tag_o,
   output logic                         err_o,
   output logic                         busy_o
);

   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

   typedef logic [CntWidth-1:0] cnt_t;
   typedef logic [IdxWidth-1:0] idx_t;

   cnt_t                cnt_q [NumPorts];
   idx_t                rr_ptr_q;
   idx_t                lock_idx_q;
   logic                lock_q;

   logic [NumPorts-1:0] eligible;
   logic                grant_valid;
   idx_t                grant_idx;
   logic                req_hs;
   idx_t                rsp_idx;
   logic                rsp_idx_ok;
   logic                rsp_hs;
   logic [NumPorts-1:0] cnt_inc;
   logic [NumPorts-1:0] cnt_dec;

   // A port competes only while it still has a free credit.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         eligible[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
      end
   end

   // Locked grants win outright; otherwise search from rr_ptr with wrap-around.
   always_comb begin
      idx_t cand;
      cand        = '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      if (lock_q) begin
         grant_valid = 1'b1;
         grant_idx   = lock_idx_q;
      end else begin
         for (int unsigned k = 0; k < NumPorts; k++) begin
            cand = IdxWidth'((32'(rr_ptr_q) + k) % NumPorts);
            if (!grant_valid && eligible[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = cand;
            end
         end
      end
   end

   assign req_hs      = grant_valid && fpu_ready_i;
   assign fpu_valid_o = rst_ni && grant_valid;
   assign fpu_data_o  = req_data_i[32'(grant_idx)*ReqWidth +: ReqWidth];
   assign fpu_tag_o   = {grant_idx, req_tag_i[32'(grant_idx)*TagWidth +: TagWidth]};

   always_comb begin
      req_ready_o = '0;
      if (rst_ni && req_hs) begin
         req_ready_o[grant_idx] = 1'b1;
      end
   end

   assign rsp_idx    = fpu_rsp_tag_i[TagWidth +: IdxWidth];
   assign rsp_idx_ok = (32'(rsp_idx) < NumPorts);
   assign rsp_hs     = fpu_rsp_valid_i && rsp_idx_ok && rsp_ready_i[rsp_idx];
   assign rsp_data_o = fpu_rsp_data_i;
   assign rsp_tag_o  = fpu_rsp_tag_i[TagWidth-1:0];

   // Responses carrying an unknown owner are swallowed so the FPU never stalls on them.
   always_comb begin
      rsp_valid_o     = '0;
      fpu_rsp_ready_o = 1'b0;
      err_o           = 1'b0;
      if (rst_ni) begin
         if (rsp_idx_ok) begin
            rsp_valid_o[rsp_idx] = fpu_rsp_valid_i;
            fpu_rsp_ready_o      = rsp_ready_i[rsp_idx];
         end else begin
            fpu_rsp_ready_o = 1'b1;
            err_o           = fpu_rsp_valid_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (req_hs) begin
         lock_q   <= 1'b0;
         rr_ptr_q <= (grant_idx == IdxWidth'(NumPorts - 1)) ? '0 : grant_idx + 1'b1;
      end else if (grant_valid) begin
         lock_q     <= 1'b1;
         lock_idx_q <= grant_idx;
      end
   end

   always_comb begin
      cnt_inc = '0;
      cnt_dec = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         cnt_inc[i] = req_hs && (grant_idx == IdxWidth'(i));
         cnt_dec[i] = rsp_hs && (rsp_idx == IdxWidth'(i));
      end
   end

   // Issue and retire on the same port in one cycle cancel out.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NumPorts; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NumPorts; i++) begin
            if (cnt_inc[i] && !cnt_dec[i]) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         if (cnt_q[i] != '0) begin
            busy_o = 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      lock_q |-> ($stable(fpu_data_o) && $stable(fpu_tag_o)));

   assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rsp_valid_o));

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      rsp_hs |-> (cnt_q[rsp_idx] != '0));

   for (genvar g = 0; g < NumPorts; g++) begin : gen_cnt_chk
      assert property (@(posedge clk_i) disable iff (!rst_ni)
         cnt_q[g] <= CntWidth'(MaxOutstanding));
   end
`endif

endmodule

// File: tb/tb_snitch_fpu_share_arbiter.sv
// Randomized bench for snitch_fpu_share_arbiter (3 ports, so an invalid response index exists),
// compared every cycle against a queue-based model of issued-but-unanswered operations.
module tb_snitch_fpu_share_arbiter;

   localparam int NP = 3;
   localparam int RW = 16;
   localparam int SW = 12;
   localparam int TW = 7;
   localparam int MO = 4;
   localparam int IW = 2;

   logic               clk_i  = 1'b0;
   logic               rst_ni = 1'b1;
   logic [NP-1:0]      req_valid_i;
   logic [NP-1:0]      req_ready_o;
   logic [NP*RW-1:0]   req_data_i;
   logic [NP*TW-1:0]   req_tag_i;
   logic               fpu_valid_o;
   logic               fpu_ready_i;
   logic [RW-1:0]      fpu_data_o;
   logic [TW+IW-1:0]   fpu_tag_o;
   logic               fpu_rsp_valid_i;
   logic               fpu_rsp_ready_o;
   logic [SW-1:0]      fpu_rsp_data_i;
   logic [TW+IW-1:0]   fpu_rsp_tag_i;
   logic [NP-1:0]      rsp_valid_o;
   logic [NP-1:0]      rsp_ready_i;
   logic [SW-1:0]      rsp_data_o;
   logic [TW-1:0]      rsp_tag_o;
   logic               err_o;
   logic               busy_o;

   int checks   = 0;
   int failures = 0;

   // Model state: pending core requests, ops in flight (by owner port), held FPU response.
   logic          pending [NP];
   logic [RW-1:0] p_data  [NP];
   logic [TW-1:0] p_tag   [NP];
   int            inflight_q [$];
   logic          rsp_present;
   int            rsp_k;
   int            rsp_port;
   logic [TW-1:0] rsp_ltag;
   int            hold_port;
   int            last_port;
   int            req_pct;
   int            rsp_pct;
   int            err_seen;
   int            full_seen;

   always #5 clk_i = ~clk_i;

   snitch_fpu_share_arbiter #(
      .NumPorts(NP), .ReqWidth(RW), .RspWidth(SW), .TagWidth(TW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_data_i(req_data_i), .req_tag_i(req_tag_i),
      .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
      .fpu_data_o(fpu_data_o), .fpu_tag_o(fpu_tag_o),
      .fpu_rsp_valid_i(fpu_rsp_valid_i), .fpu_rsp_ready_o(fpu_rsp_ready_o),
      .fpu_rsp_data_i(fpu_rsp_data_i), .fpu_rsp_tag_i(fpu_rsp_tag_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
      .err_o(err_o), .busy_o(busy_o)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   function automatic int outstanding(input int p);
      int c = 0;
      foreach (inflight_q[i]) if (inflight_q[i] == p) c++;
      return c;
   endfunction

   function automatic void clearModel();
      for (int p = 0; p < NP; p++) begin
         pending[p] = 1'b0;
         p_data[p]  = '0;
         p_tag[p]   = '0;
      end
      inflight_q.delete();
      rsp_present = 1'b0;
      rsp_k       = 0;
      rsp_port    = 0;
      rsp_ltag    = '0;
      hold_port   = -1;
      last_port   = NP - 1;
   endfunction

   task automatic driveIdle();
      req_valid_i     = '0;
      req_data_i      = '0;
      req_tag_i       = '0;
      fpu_ready_i     = 1'b0;
      fpu_rsp_valid_i = 1'b0;
      fpu_rsp_data_i  = '0;
      fpu_rsp_tag_i   = '0;
      rsp_ready_i     = '0;
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_fpu_valid", 64'(fpu_valid_o), 64'd0);
      checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      checkOutput("rst_rsp_ready", 64'(fpu_rsp_ready_o), 64'd0);
      checkOutput("rst_err", 64'(err_o), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
   endtask

   // Cores hold a request until it is accepted; the FPU holds a response until it is taken.
   task automatic applyStimulus();
      for (int p = 0; p < NP; p++) begin
         if (!pending[p] && ($urandom_range(0, 99) < req_pct)) begin
            pending[p] = 1'b1;
            p_data[p]  = RW'($urandom);
            p_tag[p]   = TW'($urandom);
         end
         req_valid_i[p]          = pending[p];
         req_data_i[p*RW +: RW]  = p_data[p];
         req_tag_i[p*TW +: TW]   = p_tag[p];
      end
      fpu_ready_i = ($urandom_range(0, 99) < 70);
      if (!rsp_present) begin
         rsp_ltag = TW'($urandom);
         if (inflight_q.size() > 0 && ($urandom_range(0, 99) < rsp_pct)) begin
            rsp_present = 1'b1;
            rsp_k       = $urandom_range(0, inflight_q.size() - 1);
            rsp_port    = inflight_q[rsp_k];
         end else if ($urandom_range(0, 99) < 3) begin
            rsp_present = 1'b1;
            rsp_port    = NP;
         end else begin
            rsp_port = $urandom_range(0, NP);
         end
      end
      fpu_rsp_valid_i = rsp_present;
      fpu_rsp_tag_i   = {IW'(rsp_port), rsp_ltag};
      fpu_rsp_data_i  = SW'($urandom);
      rsp_ready_i     = NP'($urandom);
   endtask

   task automatic evaluateCycle();
      int            grant;
      int            p;
      logic          exp_valid;
      logic [NP-1:0] exp_rsp_valid;
      logic          exp_rsp_ready;
      logic          exp_err;
      exp_valid = 1'b0;
      grant     = 0;
      if (hold_port >= 0) begin
         exp_valid = 1'b1;
         grant     = hold_port;
      end else begin
         for (int j = 1; j <= NP; j++) begin
            p = (last_port + j) % NP;
            if (!exp_valid && pending[p] && outstanding(p) < MO) begin
               exp_valid = 1'b1;
               grant     = p;
            end
         end
      end
      for (int q = 0; q < NP; q++) begin
         if (pending[q] && outstanding(q) == MO) full_seen++;
      end

      checkOutput("fpu_valid", 64'(fpu_valid_o), 64'(exp_valid));
      checkOutput("req_ready", 64'(req_ready_o), (exp_valid && fpu_ready_i) ? (64'd1 << grant) : 64'd0);
      if (exp_valid) begin
         checkOutput("fpu_data", 64'(fpu_data_o), 64'(p_data[grant]));
         checkOutput("fpu_tag", 64'(fpu_tag_o), 64'({IW'(grant), p_tag[grant]}));
      end

      if (rsp_port < NP) begin
         exp_rsp_valid = fpu_rsp_valid_i ? NP'(1 << rsp_port) : '0;
         exp_rsp_ready = rsp_ready_i[rsp_port];
         exp_err       = 1'b0;
      end else begin
         exp_rsp_valid = '0;
         exp_rsp_ready = 1'b1;
         exp_err       = fpu_rsp_valid_i;
      end
      checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp_valid));
      checkOutput("fpu_rsp_ready", 64'(fpu_rsp_ready_o), 64'(exp_rsp_ready));
      checkOutput("err", 64'(err_o), 64'(exp_err));
      checkOutput("rsp_data", 64'(rsp_data_o), 64'(fpu_rsp_data_i));
      checkOutput("rsp_tag", 64'(rsp_tag_o), 64'(rsp_ltag));
      checkOutput("busy", 64'(busy_o), 64'(inflight_q.size() != 0));

      if (fpu_rsp_valid_i) begin
         if (rsp_port >= NP) begin
            rsp_present = 1'b0;
            err_seen++;
         end else if (rsp_ready_i[rsp_port]) begin
            inflight_q.delete(rsp_k);
            rsp_present = 1'b0;
         end
      end
      if (exp_valid) begin
         if (fpu_ready_i) begin
            inflight_q.push_back(grant);
            pending[grant] = 1'b0;
            last_port      = grant;
            hold_port      = -1;
         end else begin
            hold_port = grant;
         end
      end
   endtask

   // Reset lands mid-cycle with traffic still driven; outputs must drop at once.
   task automatic resetMidTraffic();
      #1 rst_ni = 1'b0;
      #1;
      checkResetOutputs();
      clearModel();
      driveIdle();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      err_seen  = 0;
      full_seen = 0;
      req_pct   = 0;
      rsp_pct   = 0;
      clearModel();
      driveIdle();
      #1 rst_ni = 1'b0;
      req_valid_i     = '1;
      fpu_ready_i     = 1'b1;
      fpu_rsp_valid_i = 1'b1;
      fpu_rsp_tag_i   = {IW'(1), TW'(7'h2A)};
      rsp_ready_i     = '1;
      #2;
      checkResetOutputs();
      driveIdle();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int cycle = 0; cycle < 1200; cycle++) begin
         @(posedge clk_i);
         #1;
         if (cycle < 350) begin
            req_pct = 70;
            rsp_pct = 5;
         end else if (cycle < 700) begin
            req_pct = 50;
            rsp_pct = 60;
         end else begin
            req_pct = 60;
            rsp_pct = 30;
         end
         applyStimulus();
         if (cycle == 700) begin
            resetMidTraffic();
         end else begin
            #3;
            evaluateCycle();
         end
      end

      $display("[TB] dropped responses seen: %0d, credit-blocked port cycles: %0d", err_seen, full_seen);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/snitch_fpu_share_arbiter.md
Name: snitch_fpu_share_arbiter

Overview:
Shares one FPU instance between NumPorts requesting cores in a cluster (e.g., 2 or 4 integer cores feeding one FPU wrapper).
- Request path: round-robin arbitration with grant lock.
- Tagging: extends each request tag with the requester index.
- Response routing: returns each result to its owner by that index.
- Flow control: per-port outstanding-credit counters bound in-flight operations so responses are always drainable.
- Sits between the cores' FPU offload interfaces and the FPU wrapper's input and output handshakes.

Parameters:
NumPorts, 2, number of requesters (>=2)
ReqWidth, 128, opaque request payload width (operands, op, formats, rounding mode)
RspWidth, 69, opaque response payload width (result plus status)
TagWidth, 7, requester-side tag width
MaxOutstanding, 4, max in-flight ops per port (>=1)
IdxWidth, $clog2(NumPorts), derived index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NumPorts  per-port request valid
req_ready_o  out  NumPorts  per-port request ready
req_data_i  in  NumPorts*ReqWidth  per-port payload
req_tag_i  in  NumPorts*TagWidth  per-port tag
fpu_valid_o  out  1  request to FPU valid
fpu_ready_i  in  1  FPU accepts request
fpu_data_o  out  ReqWidth  granted payload
fpu_tag_o  out  TagWidth+IdxWidth  {port index, requester tag}
fpu_rsp_valid_i  in  1  FPU response valid
fpu_rsp_ready_o  out  1  response accepted
fpu_rsp_data_i  in  RspWidth  response payload
fpu_rsp_tag_i  in  TagWidth+IdxWidth  response tag
rsp_valid_o  out  NumPorts  per-port response valid (one-hot or zero)
rsp_ready_i  in  NumPorts  per-port response ready
rsp_data_o  out  RspWidth  response payload, broadcast to all ports
rsp_tag_o  out  TagWidth  low TagWidth bits of fpu_rsp_tag_i
err_o  out  1  one-cycle pulse: response with index >= NumPorts dropped
busy_o  out  1  any outstanding counter nonzero

Behaviour:
Eligibility and arbitration
- Port i is eligible when req_valid_i[i]=1 and cnt[i] < MaxOutstanding.
- If unlocked: grant the first eligible port at or after rr_ptr (wrapping).
- fpu_valid_o = 1 whenever a grant exists. fpu_data_o and fpu_tag_o come from the granted port. fpu_tag_o = {idx, req_tag_i[idx]}.

Grant lock
- If fpu_valid_o=1 and fpu_ready_i=0: set lock and hold the granted index next cycle.
- While locked, output stays on the locked port regardless of other requests. The core must keep its payload stable until accepted.

Request handshake
- req_ready_o[i] = fpu_ready_i && granted==i. All other ready bits are 0. Combinational path from fpu_ready_i is allowed.
- On handshake: clear lock, rr_ptr <= granted+1 (wrapping NumPorts-1 -> 0), cnt[granted]++.

Response routing
- idx = upper IdxWidth bits of fpu_rsp_tag_i.
- If idx < NumPorts: rsp_valid_o[idx] = fpu_rsp_valid_i and fpu_rsp_ready_o = rsp_ready_i[idx].
- On response handshake: cnt[idx]--.
- If idx >= NumPorts (non-power-of-2 NumPorts): fpu_rsp_ready_o=1, all rsp_valid_o=0, err_o=1 for that cycle, no counter change.

Counters
- Simultaneous increment and decrement on the same port leaves it unchanged.
- Counter width is $clog2(MaxOutstanding+1). No overflow: eligibility gating prevents it. Decrement at 0 is a verification assertion failure, not handled in RTL.
- Latency: zero-cycle combinational pass-through in both directions; no internal buffering.

Reset
- Async, all registers cleared: rr_ptr=0, lock=0, cnt=0.
- Outputs in reset: fpu_valid_o=0, req_ready_o=0, rsp_valid_o=0, err_o=0, busy_o=0.
- Reset asserted mid-operation discards in-flight tracking. The FPU must be reset together with this block.

Assertions
- Locked payload and tag stable while locked.
- At most one rsp_valid_o bit set.
- cnt never exceeds MaxOutstanding.

Test Plan:
- NumPorts=2, both ports valid every cycle, fpu_ready_i=1, responses returned immediately -> grants alternate 0,1,0,1; fpu_tag_o MSB alternates.
- Port 0 valid with tag 0x15, fpu_ready_i=0 for 3 cycles, port 1 raises valid in cycle 2 -> port 0 stays granted and stable; accepted in cycle 4; port 1 granted in cycle 5.
- MaxOutstanding=4, port 1 issues 4 ops with no responses -> 5th request gets req_ready_o[1]=0 while port 0 is still served; first response to port 1 re-enables it next cycle.
- Response with tag {1,0x2A} and rsp_ready_i[1]=0 for 2 cycles -> rsp_valid_o=2'b10 and fpu_rsp_ready_o=0 held; rsp_tag_o=0x2A; counter decrements only on the accepting cycle.
- Same cycle: request accepted on port 0 and response for port 0 accepted, cnt[0]=2 -> cnt[0] stays 2; busy_o=1.
- NumPorts=3, response tag index 3 -> err_o pulses for 1 cycle, fpu_rsp_ready_o=1, no rsp_valid_o; also assert rst_ni mid-traffic -> all outputs 0 and counters 0 immediately.
